// File: rtl/integration_engine.sv
// rtl/integration_engine.sv - batched a*b+c checker with a 2-stage pipeline and pass/fail statistics
module integration_engine #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [CNT_W-1:0] num_items,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     ans,
  output logic [W-1:0]     result,
  output logic             result_valid,
  output logic             match,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] ret_idx;
  logic             ff_seen;

  logic             p1_v;
  logic [W-1:0]     p1_prod;
  logic [W-1:0]     p1_c;
  logic [W-1:0]     p1_ans;
  logic             p2_v;
  logic [W-1:0]     p2_sum;
  logic             p2_eq;

  logic             accept;
  logic             start_ok;
  logic [W-1:0]     prod_lo;
  logic [W-1:0]     sum_lo;

  assign in_ready = (state == ST_RUN) && (acc_cnt < n_lat);
  assign accept   = in_valid && in_ready;
  assign start_ok = (state == ST_IDLE) && start;
  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);

  // Low W bits of a product do not depend on operand signedness, so a W-bit
  // multiply gives exactly the truncated signed 2W-bit product.
  assign prod_lo = a * b;
  assign sum_lo  = p1_prod + p1_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      n_lat   <= '0;
      acc_cnt <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + CNT_ONE;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat   <= num_items;
            acc_cnt <= '0;
            state   <= (num_items == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept && (acc_cnt == n_lat - CNT_ONE)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!p1_v && !p2_v) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p1_v         <= 1'b0;
      p1_prod      <= '0;
      p1_c         <= '0;
      p1_ans       <= '0;
      p2_v         <= 1'b0;
      p2_sum       <= '0;
      p2_eq        <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      match        <= 1'b0;
    end else begin
      p1_v <= accept;
      if (accept) begin
        p1_prod <= prod_lo;
        p1_c    <= c;
        p1_ans  <= ans;
      end
      p2_v <= p1_v;
      if (p1_v) begin
        p2_sum <= sum_lo;
        p2_eq  <= (sum_lo == p1_ans);
      end
      result_valid <= p2_v;
      if (p2_v) begin
        result <= p2_sum;
        match  <= p2_eq;
      end
    end
  end

  // Statistics advance as each item leaves stage 2, aligned with result_valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      ff_seen        <= 1'b0;
      ret_idx        <= '0;
    end else if (start_ok) begin
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      ff_seen        <= 1'b0;
      ret_idx        <= '0;
    end else if (p2_v) begin
      ret_idx <= ret_idx + CNT_ONE;
      if (p2_eq) begin
        if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_ONE;
      end else begin
        if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_ONE;
        if (!ff_seen) begin
          first_fail_idx <= ret_idx;
          ff_seen        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_integration_engine.sv
// tb/tb_integration_engine.sv - self-checking bench for integration_engine
module tb_integration_engine;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [15:0] num_items;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, c, ans;
  logic [31:0] result;
  logic        result_valid, match, busy, done;
  logic [15:0] pass_count, fail_count, first_fail_idx;

  logic        start8, v8, rdy8, rv8, m8, busy8, done8;
  logic [7:0]  n8, a8, b8, c8, ans8, res8, pc8, fc8, ff8;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  integration_engine #(.W(32), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .num_items(num_items),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c), .ans(ans),
    .result(result), .result_valid(result_valid), .match(match), .busy(busy),
    .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx)
  );

  integration_engine #(.W(8), .CNT_W(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .start(start8), .num_items(n8),
    .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .c(c8), .ans(ans8),
    .result(res8), .result_valid(rv8), .match(m8), .busy(busy8),
    .done(done8), .pass_count(pc8), .fail_count(fc8), .first_fail_idx(ff8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an item accepted on edge t retires on edge t+2;
  // done follows the last retirement by one edge.
  typedef struct {
    int          due;
    logic [31:0] res;
    bit          ok;
  } item_t;

  item_t       q[$];
  int          t, done_at, m_n, m_acc, m_ret;
  bit          m_active, m_seen, e_rv, e_match;
  int          e_pass, e_fail;
  logic [15:0] e_ffi;
  logic [31:0] e_res;

  always @(posedge aclk) begin
    if (!aresetn) begin
      q.delete();
      t = 0; done_at = -10; m_n = 0; m_acc = 0; m_ret = 0;
      m_active = 0; m_seen = 0; e_rv = 0; e_match = 0;
      e_pass = 0; e_fail = 0; e_ffi = '1; e_res = '0;
    end else begin : model_step
      int    r;
      item_t it;
      t++;
      e_rv = 0;
      if (m_active && m_acc < m_n && in_valid) begin
        r = int'($signed(a)) * int'($signed(b)) + int'($signed(c));
        it.due = t + 2; it.res = r; it.ok = (r == int'($signed(ans)));
        q.push_back(it);
        m_acc++;
      end else if (!m_active && t >= done_at + 2 && start) begin
        m_n = int'(num_items); m_acc = 0; m_ret = 0; m_seen = 0;
        e_pass = 0; e_fail = 0; e_ffi = '1;
        if (m_n == 0) done_at = t;
        else m_active = 1;
      end
      if (q.size() > 0 && q[0].due == t) begin
        it = q.pop_front();
        e_rv = 1; e_res = it.res; e_match = it.ok;
        if (it.ok) e_pass++;
        else begin
          e_fail++;
          if (!m_seen) begin e_ffi = 16'(m_ret); m_seen = 1; end
        end
        m_ret++;
        if (m_ret == m_n) done_at = t + 1;
      end
      if (m_active && t == done_at) m_active = 0;
    end
  end

  int          done_cnt = 0;
  int          acc_obs = 0;
  logic [31:0] last_res = '0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_result_valid", result_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_result", result, 0);
      chk("rst_match", match, 0);
      chk("rst_pass", pass_count, 0);
      chk("rst_fail", fail_count, 0);
      chk("rst_ffi", first_fail_idx, 16'hFFFF);
    end else begin
      chk("result_valid", result_valid, e_rv);
      if (e_rv && result_valid) begin
        chk("result", result, e_res);
        chk("match", match, e_match);
        last_res = result;
      end
      chk("done", done, t == done_at);
      chk("busy", busy, m_active);
      chk("in_ready", in_ready, m_active && m_acc < m_n);
      chk("pass_count", pass_count, e_pass);
      chk("fail_count", fail_count, e_fail);
      chk("first_fail_idx", first_fail_idx, e_ffi);
      if (done) done_cnt++;
      if (in_valid && in_ready) acc_obs++;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_items = 16'(n);
    step();
    start = 1'b0;
  endtask

  task automatic put(input bit v, input int ta, input int tb_, input int tc, input int tans);
    in_valid = v;
    a = ta; b = tb_; c = tc; ans = tans;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (done) begin seen = 1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: done not seen within 60 cycles", nm);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, a0;
    bit seen8;
    aresetn = 1'b0; start = 1'b0; num_items = '0;
    put(0, 0, 0, 0, 0);
    start8 = 1'b0; n8 = '0; v8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; ans8 = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // N=3 back-to-back, third item mismatches
    d0 = done_cnt;
    do_start(3);
    put(1, 2, 3, 4, 10);   step();
    put(1, -1, 5, 0, -5);  step();
    put(1, 7, 7, 1, 40);   step();
    put(0, 0, 0, 0, 0);
    wait_done("n3_done");
    chk("n3_pass", pass_count, 2);
    chk("n3_fail", fail_count, 1);
    chk("n3_ffi", first_fail_idx, 2);
    chk("n3_last_result", last_res, 50);
    step();
    chk("n3_done_once", done_cnt - d0, 1);

    // zero-length batch
    repeat (2) step();
    do_start(0);
    @(negedge aclk);
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    chk("n0_pass", pass_count, 0);
    chk("n0_fail", fail_count, 0);
    chk("n0_ffi", first_fail_idx, 16'hFFFF);
    step();

    // 8-bit wrap-around: 127*2 = 254 = -2 mod 256
    repeat (2) step();
    start8 = 1'b1; n8 = 8'd1; step(); start8 = 1'b0;
    v8 = 1'b1; a8 = 8'd127; b8 = 8'd2; c8 = 8'd0; ans8 = 8'hFE; step();
    v8 = 1'b0;
    seen8 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (rv8) begin seen8 = 1; break; end
    end
    chk("w8_result_valid_seen", seen8, 1);
    chk("w8_result", res8, 8'hFE);
    chk("w8_match", m8, 1);
    @(negedge aclk);
    @(negedge aclk);
    chk("w8_pass", pc8, 1);

    // N=4 with gapped valid; the 7th-cycle tuple must be ignored
    repeat (3) step();
    a0 = acc_obs;
    do_start(4);
    for (int i = 0; i < 7; i++) begin
      put((7'b1101101 >> i) & 1, i + 1, 3, -2, (i + 1) * 3 - 2);
      step();
    end
    put(0, 0, 0, 0, 0);
    wait_done("n4_done");
    chk("n4_accepted", acc_obs - a0, 4);
    chk("n4_pass", pass_count, 4);
    chk("n4_fail", fail_count, 0);
    chk("n4_ffi", first_fail_idx, 16'hFFFF);

    // start during RUN is ignored
    repeat (2) step();
    do_start(2);
    put(1, 5, 5, 5, 30); step();
    start = 1'b1; num_items = 16'd5;
    put(1, -3, 4, 2, -10); step();
    start = 1'b0;
    put(1, 1, 1, 1, 2); step();
    put(0, 0, 0, 0, 0);
    wait_done("restart_done");
    chk("restart_total", pass_count + fail_count, 2);
    chk("restart_pass", pass_count, 2);

    // reset mid-batch, then a fresh single-item batch
    repeat (2) step();
    do_start(5);
    put(1, 1, 2, 3, 5); step();
    put(1, 2, 2, 2, 6); step();
    put(0, 0, 0, 0, 0);
    d0 = done_cnt;
    aresetn = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    repeat (8) step();
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle_pass", pass_count, 0);
    do_start(1);
    put(1, 1, 1, 1, 0); step();
    put(0, 0, 0, 0, 0);
    wait_done("post_rst_done");
    chk("post_rst_fail", fail_count, 1);
    chk("post_rst_pass", pass_count, 0);
    chk("post_rst_ffi", first_fail_idx, 0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/integration_engine.md
INTEGRATION_ENGINE -- requirements
Module: integration_engine

Interface
REQ-001 Parameter W, default 32: signed two's-complement operand and result width.
REQ-002 Parameter CNT_W, default 16: width of the item-count, pass/fail counter and index fields.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 aclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a batch; sampled only in IDLE.
REQ-007 num_items  in  CNT_W  batch length, latched when start is accepted.
REQ-008 in_valid  in  1  operand tuple valid.
REQ-009 in_ready  out  1  block accepts a tuple on this edge when in_valid is also high.
REQ-010 a, b, c, ans  in  W each  signed operands and expected answer.
REQ-011 result  out  W  computed a*b+c of the most recent retired item.
REQ-012 result_valid  out  1  one-cycle strobe per retired item.
REQ-013 match  out  1  qualifies result_valid; high when result equals ans.
REQ-014 busy  out  1  high in RUN and DRAIN.
REQ-015 done  out  1  one-cycle strobe at batch completion.
REQ-016 pass_count, fail_count  out  CNT_W each  batch statistics.
REQ-017 first_fail_idx  out  CNT_W  zero-based index of the first mismatching item; all-ones if none.

Function
REQ-018 Arithmetic SHALL be: full 2W-bit signed product a*b, plus sign-extended c, truncated to the low W bits (modulo 2^W); match SHALL be an exact W-bit compare with ans.
REQ-019 Pipeline SHALL have 2 stages: stage 1 registers the product, c and ans; stage 2 registers the sum and compare. A tuple accepted on edge k SHALL produce result_valid on the cycle after edge k+2.
REQ-020 The pipeline SHALL accept one tuple per cycle with no bubbles under continuous in_valid; gaps in in_valid SHALL propagate as result_valid gaps.
REQ-021 in_ready SHALL be high only in RUN while accepted < num_items; a tuple is accepted only when in_valid and in_ready are both high.
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-023 IDLE -> RUN on start with num_items != 0. On that transition the block SHALL latch num_items, clear pass_count and fail_count, and set first_fail_idx to all-ones.
REQ-024 IDLE -> DONE on start with num_items == 0, with the counters cleared as in REQ-023.
REQ-025 RUN -> DRAIN on the edge that accepts item num_items-1.
REQ-026 DRAIN -> DONE once the final item has retired (both pipeline stages empty).
REQ-027 In DONE, done SHALL be 1 for exactly one cycle; then DONE -> IDLE.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 Each retired item SHALL increment pass_count or fail_count; each counter SHALL saturate at 2^CNT_W-1.
REQ-030 first_fail_idx SHALL be written only by the first mismatch in a batch.
REQ-031 Statistics and result SHALL hold their values after done until the next accepted start.

Reset
REQ-032 While aresetn is low, all outputs and internal registers SHALL be 0, except first_fail_idx, which SHALL be all-ones; the FSM SHALL be in IDLE and the pipeline empty.
REQ-033 Reset asserted mid-batch SHALL abandon the batch: no done, no result_valid. After reset is released, a new start SHALL work normally.

Verification
REQ-034 W=32, N=3, back-to-back tuples (2,3,4,ans 10), (-1,5,0,ans -5), (7,7,1,ans 40) -> result_valid strobes 2 cycles after each acceptance, match 1,1,0; done once; pass_count=2, fail_count=1, first_fail_idx=2.
REQ-035 start with num_items=0 -> done for one cycle on the cycle after start; busy never high; pass_count=0, fail_count=0, first_fail_idx all-ones.
REQ-036 W=8: a=127, b=2, c=0, ans=-2 (0xFE) -> result 0xFE, match=1 (wrap-around modulo 2^8).
REQ-037 N=4 with in_valid toggling 1,0,1,1,0,1,1 -> exactly 4 tuples accepted; in_ready low after the 4th; the extra valid tuple is ignored; done after the final result_valid.
REQ-038 aresetn pulsed low after 2 of 5 items are accepted -> all outputs at reset values, no done; next start with N=1 completes with pass_count 1 or fail_count 1.
REQ-039 start pulsed during RUN with a different num_items -> ignored; the batch completes with the original length.
